cpu_dispatcher: RTL and testbench
=================================

Name: cpu_dispatcher

Overview:
- Host-side controller for the multicore array: accepts jobs over a valid/ready channel and assigns each to an idle core with a one-cycle cpu_start pulse.
- Consumes each core's one-cycle cpu_done pulse and reports each completion, or a watchdog timeout, one per cycle on a completion port.
- Sits between the job source or host interface and the NUM_CORES cpu instances. It is the initiator/consumer end of the cpu start/done interface.

Parameters:
- NUM_CORES, 4, number of cores managed (1..16)
- ID_W, 8, width of the job identifier
- TIMEOUT, 200, RUN cycles without cpu_done before a core is declared timed out (must fit in 8 bits, >=1)
- CORE_W, 2, width of the core index; must equal clog2(NUM_CORES), minimum 1

Ports:
- clk  in  1  system clock, all logic on the rising edge
- reset  in  1  synchronous, active-high reset
- job_valid  in  1  job offered
- job_id  in  ID_W  job identifier, valid with job_valid
- job_ready  out  1  a core is IDLE; combinational from registered state only
- cpu_start  out  NUM_CORES  one-cycle start pulse per core, registered
- cpu_done  in  NUM_CORES  one-cycle done pulse from each core
- busy  out  NUM_CORES  core not IDLE (RUN or PEND)
- done_valid  out  1  completion reported this cycle, registered
- done_core  out  CORE_W  core index of the reported completion
- done_id  out  ID_W  job_id that was dispatched to that core
- done_err  out  1  the reported completion was a timeout
- timeout_err  out  1  sticky; set on any timeout, cleared only by reset
- jobs_completed  out  16  count of reported completions (error and normal), wraps 0xFFFF->0

Behaviour:
- Per-core states: IDLE, RUN, PEND. Per-core registers: job_id, 8-bit watchdog counter, err flag.
- Reset (synchronous, including mid-operation):
  - All cores go to IDLE.
  - cpu_start=0, done_valid=0, done_core=0, done_id=0, done_err=0, timeout_err=0, jobs_completed=0, busy=0.
  - Cores already running are abandoned and no completion is reported for them.
- Dispatch:
  - job_ready = OR of (state==IDLE).
  - On a cycle with job_valid && job_ready, the lowest-index IDLE core i is selected.
  - At the next edge: state[i]<=RUN, job_id[i] stored, watchdog[i]<=0, cpu_start[i]<=1 for exactly that cycle.
  - At most one dispatch per cycle.
  - Latency: accept edge to start pulse visible = 1 cycle.
- RUN:
  - cpu_done[i]=1 -> PEND with err=0.
  - Otherwise watchdog increments. When it reaches TIMEOUT-1 without done, the core moves to PEND with err=1.
  - cpu_done arriving in the same cycle as the start pulse counts as done.
  - cpu_done while IDLE or PEND is ignored and does not count as a protocol error.
- Reporting:
  - Each cycle, the lowest-index PEND core j (if any) drives done_valid=1, done_core=j, done_id=job_id[j], done_err=err[j] at the next edge.
  - Core j returns to IDLE on that same edge.
  - Simultaneous dones are serialised lowest index first, one per cycle. A PEND core is never re-dispatched before it is reported.
  - A core returned to IDLE is eligible for dispatch from the following cycle (job_ready is computed from registered state).
- timeout_err is set on the edge where any core enters PEND with err=1.
- jobs_completed increments by 1 on every done_valid cycle.
- No backpressure on the completion port: the consumer must accept every done_valid.

Decomposition:
- Package cpu_dispatch_pkg holds:
  - core state enum: IDLE=2'd0, RUN=2'd1, PEND=2'd2
  - watchdog width constant: WD_W=8
- One natural sub-module, core_slot: holds one core's state, job_id, watchdog and err flag. It is instantiated NUM_CORES times.
- The dispatcher top keeps the two lowest-index priority encoders (idle select, pend select) and the counters.

Test Plan:
- Single job: job_id=0x5A accepted at cycle 0 -> cpu_start=4'b0001 at cycle 1; cpu_done[0] pulsed at cycle 10 -> done_valid at cycle 11 with done_core=0, done_id=0x5A, done_err=0, jobs_completed=1.
- Fill all cores: ids 1,2,3,4 offered back-to-back -> start pulses on cores 0,1,2,3 on consecutive cycles; job_ready=0 afterwards; a fifth job is held until a completion is reported.
- Simultaneous done: cores 1 and 3 pulse cpu_done in the same cycle -> done_core=1 in one cycle and done_core=3 in the next; busy clears on each of those edges.
- Watchdog: core 0 started and never pulsed with TIMEOUT=200 -> done_valid with done_err=1 about 201 cycles after start; timeout_err=1 and stays set.
- Reset mid-run: two cores in RUN, reset asserted for 1 cycle -> busy=0, no done_valid, counters=0; a cpu_done that arrives later is ignored.
- Stray done: cpu_done[2] pulsed while core 2 is IDLE -> no done_valid, jobs_completed unchanged.

Source files
------------

// File: rtl/cpu_dispatch_pkg.sv
// Shared types for the cpu dispatcher.
// Core slot states and watchdog sizing.
package cpu_dispatch_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    PEND = 2'd2
  } core_st_e;

  localparam int WD_W = 8;

endpackage

// File: rtl/core_slot.sv
// One managed core: state, dispatched job id,
// watchdog and completion error flag.
module core_slot
  import cpu_dispatch_pkg::*;
#(
  parameter int ID_W    = 8,
  parameter int TIMEOUT = 200
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start_i,
  input  logic [ID_W-1:0] id_i,
  input  logic            done_i,
  input  logic            ack_i,
  output core_st_e        st_o,
  output logic [ID_W-1:0] id_o,
  output logic            err_o,
  output logic            to_o
);

  localparam logic [WD_W-1:0] WD_MAX =
    WD_W'(TIMEOUT - 1);

  core_st_e        st_q, st_d;
  logic [ID_W-1:0] id_q, id_d;
  logic [WD_W-1:0] wd_q, wd_d;
  logic            err_q, err_d;

  always_comb begin
    st_d  = st_q;
    id_d  = id_q;
    wd_d  = wd_q;
    err_d = err_q;
    to_o  = 1'b0;
    unique case (st_q)
      IDLE: begin
        if (start_i) begin
          st_d  = RUN;
          id_d  = id_i;
          wd_d  = '0;
          err_d = 1'b0;
        end
      end
      RUN: begin
        if (done_i) begin
          st_d  = PEND;
          err_d = 1'b0;
        end else if (wd_q == WD_MAX) begin
          st_d  = PEND;
          err_d = 1'b1;
          to_o  = 1'b1;
        end else begin
          wd_d = wd_q + 1'b1;
        end
      end
      PEND: begin
        if (ack_i) st_d = IDLE;
      end
      default: st_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      st_q  <= IDLE;
      id_q  <= '0;
      wd_q  <= '0;
      err_q <= 1'b0;
    end else begin
      st_q  <= st_d;
      id_q  <= id_d;
      wd_q  <= wd_d;
      err_q <= err_d;
    end
  end

  assign st_o  = st_q;
  assign id_o  = id_q;
  assign err_o = err_q;

endmodule

// File: rtl/cpu_dispatcher.sv
// Host-side job dispatcher for the multicore array:
// starts jobs on idle cores and serialises completions.
module cpu_dispatcher
  import cpu_dispatch_pkg::*;
#(
  parameter int NUM_CORES = 4,
  parameter int ID_W      = 8,
  parameter int TIMEOUT   = 200,
  parameter int CORE_W    = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 job_valid,
  input  logic [ID_W-1:0]      job_id,
  output logic                 job_ready,
  output logic [NUM_CORES-1:0] cpu_start,
  input  logic [NUM_CORES-1:0] cpu_done,
  output logic [NUM_CORES-1:0] busy,
  output logic                 done_valid,
  output logic [CORE_W-1:0]    done_core,
  output logic [ID_W-1:0]      done_id,
  output logic                 done_err,
  output logic                 timeout_err,
  output logic [15:0]          jobs_completed
);

  core_st_e             st_w  [NUM_CORES];
  logic [ID_W-1:0]      id_w  [NUM_CORES];
  logic [NUM_CORES-1:0] err_w;
  logic [NUM_CORES-1:0] to_w;

  logic [NUM_CORES-1:0] idle_oh, pend_oh, disp;
  logic                 idle_hit, pend_hit;
  logic [CORE_W-1:0]    pend_idx;
  logic [ID_W-1:0]      pend_id;
  logic                 pend_err;

  logic [NUM_CORES-1:0] start_q;
  logic                 dv_q;
  logic [CORE_W-1:0]    dcore_q;
  logic [ID_W-1:0]      did_q;
  logic                 derr_q;
  logic                 terr_q;
  logic [15:0]          jobs_q;

  // Scan high-to-low so the lowest index wins.
  always_comb begin
    idle_oh  = '0;
    pend_oh  = '0;
    idle_hit = 1'b0;
    pend_hit = 1'b0;
    pend_idx = '0;
    pend_id  = '0;
    pend_err = 1'b0;
    for (int i = NUM_CORES - 1; i >= 0; i--) begin
      if (st_w[i] == IDLE) begin
        idle_oh    = '0;
        idle_oh[i] = 1'b1;
        idle_hit   = 1'b1;
      end
      if (st_w[i] == PEND) begin
        pend_oh    = '0;
        pend_oh[i] = 1'b1;
        pend_hit   = 1'b1;
        pend_idx   = CORE_W'(i);
        pend_id    = id_w[i];
        pend_err   = err_w[i];
      end
    end
  end

  assign job_ready = idle_hit;
  assign disp = (job_valid && idle_hit) ? idle_oh : '0;

  for (genvar g = 0; g < NUM_CORES; g++) begin : g_slot
    core_slot #(
      .ID_W    (ID_W),
      .TIMEOUT (TIMEOUT)
    ) u_slot (
      .clk     (clk),
      .reset   (reset),
      .start_i (disp[g]),
      .id_i    (job_id),
      .done_i  (cpu_done[g]),
      .ack_i   (pend_oh[g]),
      .st_o    (st_w[g]),
      .id_o    (id_w[g]),
      .err_o   (err_w[g]),
      .to_o    (to_w[g])
    );
    assign busy[g] = (st_w[g] != IDLE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      start_q <= '0;
      dv_q    <= 1'b0;
      dcore_q <= '0;
      did_q   <= '0;
      derr_q  <= 1'b0;
      terr_q  <= 1'b0;
      jobs_q  <= '0;
    end else begin
      start_q <= disp;
      dv_q    <= pend_hit;
      if (pend_hit) begin
        dcore_q <= pend_idx;
        did_q   <= pend_id;
        derr_q  <= pend_err;
        jobs_q  <= jobs_q + 16'd1;
      end
      if (|to_w) terr_q <= 1'b1;
    end
  end

  assign cpu_start      = start_q;
  assign done_valid     = dv_q;
  assign done_core      = dcore_q;
  assign done_id        = did_q;
  assign done_err       = derr_q;
  assign timeout_err    = terr_q;
  assign jobs_completed = jobs_q;

endmodule

// File: tb/tb_cpu_dispatcher.sv
// Directed self-checking bench for cpu_dispatcher.
// Inputs change and outputs are sampled on negedge.
module tb_cpu_dispatcher;

  logic       clk = 1'b0;
  logic       reset;
  logic       job_valid;
  logic [7:0] job_id;
  logic       job_ready;
  logic [3:0] cpu_start;
  logic [3:0] cpu_done;
  logic [3:0] busy;
  logic       done_valid;
  logic [1:0] done_core;
  logic [7:0] done_id;
  logic       done_err;
  logic       timeout_err;
  logic [15:0] jobs_completed;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  cpu_dispatcher #(
    .NUM_CORES (4),
    .ID_W      (8),
    .TIMEOUT   (200),
    .CORE_W    (2)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .job_valid      (job_valid),
    .job_id         (job_id),
    .job_ready      (job_ready),
    .cpu_start      (cpu_start),
    .cpu_done       (cpu_done),
    .busy           (busy),
    .done_valid     (done_valid),
    .done_core      (done_core),
    .done_id        (done_id),
    .done_err       (done_err),
    .timeout_err    (timeout_err),
    .jobs_completed (jobs_completed)
  );

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h",
               tag, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic pulse_done(input logic [3:0] m);
    cpu_done = m;
    tick();
    cpu_done = 4'b0;
  endtask

  int n;

  initial begin
    reset     = 1'b1;
    job_valid = 1'b0;
    job_id    = 8'h00;
    cpu_done  = 4'b0;
    tick();
    tick();
    reset = 1'b0;
    tick();

    check("rst_busy",  32'(busy), 32'h0);
    check("rst_dv",    32'(done_valid), 32'h0);
    check("rst_jobs",  32'(jobs_completed), 32'h0);
    check("rst_terr",  32'(timeout_err), 32'h0);
    check("rst_start", 32'(cpu_start), 32'h0);
    check("rst_ready", 32'(job_ready), 32'h1);

    // single job
    job_valid = 1'b1;
    job_id    = 8'h5A;
    tick();
    job_valid = 1'b0;
    check("j1_start", 32'(cpu_start), 32'h1);
    check("j1_busy",  32'(busy), 32'h1);
    repeat (8) tick();
    check("j1_nostart", 32'(cpu_start), 32'h0);
    pulse_done(4'b0001);
    check("j1_dv_lat", 32'(done_valid), 32'h0);
    tick();
    check("j1_dv",   32'(done_valid), 32'h1);
    check("j1_core", 32'(done_core), 32'h0);
    check("j1_id",   32'(done_id), 32'h5A);
    check("j1_err",  32'(done_err), 32'h0);
    check("j1_jobs", 32'(jobs_completed), 32'h1);
    check("j1_idle", 32'(busy), 32'h0);

    // fill all cores back-to-back
    for (int k = 1; k <= 4; k++) begin
      job_valid = 1'b1;
      job_id    = 8'(k);
      tick();
      check($sformatf("fill_start%0d", k),
            32'(cpu_start), 32'(1 << (k - 1)));
    end
    job_id = 8'd5;
    check("full_ready", 32'(job_ready), 32'h0);
    check("full_busy",  32'(busy), 32'hF);
    tick();
    check("held_start", 32'(cpu_start), 32'h0);
    pulse_done(4'b0100);
    check("pend_ready", 32'(job_ready), 32'h0);
    tick();
    check("c2_dv",    32'(done_valid), 32'h1);
    check("c2_core",  32'(done_core), 32'h2);
    check("c2_id",    32'(done_id), 32'h3);
    check("c2_ready", 32'(job_ready), 32'h1);
    tick();
    job_valid = 1'b0;
    check("j5_start", 32'(cpu_start), 32'h4);
    check("j5_dv",    32'(done_valid), 32'h0);

    // simultaneous done on cores 1 and 3
    pulse_done(4'b1010);
    tick();
    check("sim1_dv",   32'(done_valid), 32'h1);
    check("sim1_core", 32'(done_core), 32'h1);
    check("sim1_id",   32'(done_id), 32'h2);
    check("sim1_busy", 32'(busy), 32'hD);
    tick();
    check("sim2_dv",   32'(done_valid), 32'h1);
    check("sim2_core", 32'(done_core), 32'h3);
    check("sim2_id",   32'(done_id), 32'h4);
    check("sim2_busy", 32'(busy), 32'h5);
    tick();
    check("sim_end_dv", 32'(done_valid), 32'h0);
    check("sim_jobs",   32'(jobs_completed), 32'h4);

    // reset with cores 0 and 2 running
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("mr_busy",  32'(busy), 32'h0);
    check("mr_dv",    32'(done_valid), 32'h0);
    check("mr_jobs",  32'(jobs_completed), 32'h0);
    check("mr_did",   32'(done_id), 32'h0);
    pulse_done(4'b0101);
    tick();
    check("mr_late_dv",   32'(done_valid), 32'h0);
    check("mr_late_busy", 32'(busy), 32'h0);
    check("mr_late_jobs", 32'(jobs_completed), 32'h0);

    // done in the same cycle as the start pulse
    job_valid = 1'b1;
    job_id    = 8'h33;
    tick();
    job_valid = 1'b0;
    check("co_start", 32'(cpu_start), 32'h1);
    pulse_done(4'b0001);
    tick();
    check("co_dv", 32'(done_valid), 32'h1);
    check("co_id", 32'(done_id), 32'h33);
    check("co_err", 32'(done_err), 32'h0);
    tick();

    // watchdog on core 0
    job_valid = 1'b1;
    job_id    = 8'h77;
    tick();
    job_valid = 1'b0;
    check("wd_start", 32'(cpu_start), 32'h1);
    n = 0;
    while (!done_valid && n < 300) begin
      tick();
      n++;
    end
    check("wd_latency", 32'(n), 32'd201);
    check("wd_dv",   32'(done_valid), 32'h1);
    check("wd_core", 32'(done_core), 32'h0);
    check("wd_id",   32'(done_id), 32'h77);
    check("wd_err",  32'(done_err), 32'h1);
    check("wd_terr", 32'(timeout_err), 32'h1);
    check("wd_jobs", 32'(jobs_completed), 32'h2);
    repeat (5) tick();
    check("wd_sticky", 32'(timeout_err), 32'h1);
    check("wd_once",   32'(done_valid), 32'h0);

    // stray done on an idle core
    pulse_done(4'b0100);
    tick();
    check("stray_dv",   32'(done_valid), 32'h0);
    check("stray_jobs", 32'(jobs_completed), 32'h2);
    check("stray_busy", 32'(busy), 32'h0);

    // reset clears the sticky timeout flag
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("rst2_terr", 32'(timeout_err), 32'h0);
    check("rst2_derr", 32'(done_err), 32'h0);

    $display("[TB] %0d tests run, %0d failed",
             n_tests, n_fail);
    $finish;
  end

endmodule
